muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit; the producer side of the HI/LO register write port.
//  EX issues MULT/MULTU/DIV/DIVU; the unit computes over multiple cycles.
//  It then drives one write pulse (w_en_hi/data_hi, w_en_lo/data_lo) into the HI/LO register.
//  busy stalls the pipeline on any HI/LO reader or new mul/div until the write lands.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk        in   1      clock, all state on rising edge
//  resetn     in   1      reset, asynchronous, active-low
//  start      in   1      issue request; sampled only in IDLE
//  op         in   2      0=MULT 1=MULTU 2=DIV 3=DIVU (`muldiv_op_*)
//  src_a      in   WIDTH  multiplicand / dividend
//  src_b      in   WIDTH  multiplier / divisor
//  cancel     in   1      pipeline flush; aborts the operation in flight
//  busy       out  1      high whenever state != IDLE
//  w_en_hi    out  1      one-cycle HI write strobe
//  data_hi    out  WIDTH  HI result (product[63:32] / remainder)
//  w_en_lo    out  1      one-cycle LO write strobe
//  data_lo    out  WIDTH  LO result (product[31:0] / quotient)
// BEHAVIOUR
//  Reset: async on resetn low; state=IDLE; busy, w_en_*, data_* all 0; iteration counter 0.
//  FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 && cancel=0 latches op, src_a, src_b and goes to CALC.
//         Signed ops store magnitudes plus two sign flags: neg_q = sa^sb, neg_r = sa.
//   CALC: WIDTH cycles, counter 0..WIDTH-1.
//         Mul: radix-2 shift-add into a 2*WIDTH accumulator.
//         Div: radix-2 restoring; remainder/quotient shift; subtract if rem >= divisor.
//   FIX:  1 cycle. Signed mul with neg_q: negate the 64-bit product.
//         Signed div: negate quotient if neg_q; negate remainder if neg_r.
//   DONE: 1 cycle. w_en_hi = w_en_lo = 1; data_hi/data_lo valid; then IDLE.
//  Outputs are registered. w_en_* is low in all states except DONE.
//  data_* holds its last value outside DONE.
//  Latency: start sampled at edge N -> w_en_* high during cycle N+WIDTH+2 (34 for WIDTH=32).
//  busy rises the cycle after start is accepted and falls the cycle after DONE.
//  start while busy: ignored, no queueing; the pipeline guarantees it is not issued.
//  cancel: synchronous, any state -> IDLE next edge, no write pulse.
//   cancel and start together in IDLE: cancel wins, nothing latched.
//   cancel during DONE: the pulse already driven in that cycle stands.
//  Divide by zero (DIV or DIVU): skip the FIX negation; LO = all-ones; HI = src_a unchanged.
//  DIV 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural magnitude result, no trap).
//  Mid-operation async reset: immediate return to reset values; no partial write.
// CONFIGURATION
//  MUL_SINGLE_CYCLE_EN defined:
//   MULT/MULTU compute with a signed/unsigned `*` at the accept edge and go IDLE -> DONE.
//   The w_en_* pulse is in cycle N+1. Divide path is unchanged.
//  MUL_SINGLE_CYCLE_EN undefined: multiply uses the iterative CALC/FIX path (WIDTH+2 latency).
// STRUCTURE
//  defines_cpu.vh holds:
//   `muldiv_op_mult/multu/div/divu (2-bit)
//   FSM state encodings `md_idle/`md_calc/`md_fix/`md_done
//   existing `data_bus, `zero_32, `rstn_enable
//  One sub-module, div_radix2_step: combinational single divide step.
//   Inputs: rem, quotient, divisor. Outputs: next rem and quotient.
//   It is instantiated once; the multiply step stays inline.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; pulse at cycle 34 (1 with macro).
//  MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly cycles 1..34.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIVU 100/7 -> LO=14, HI=2.
//  DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
//   DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  DIVU started, cancel at CALC cycle 10 -> no w_en_*, busy low next cycle.
//   New MULTU 6*7 then accepted -> LO=42, HI=0.
//  resetn low mid-CALC, asynchronous to clk -> busy/w_en_*/data_* are 0 before the next edge.
//   After release, a fresh op completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state type and op-decoding helpers for the multiply/divide unit.
package muldiv_unit_pkg;

   localparam logic [1:0] MULDIV_OP_MULT  = 2'd0;
   localparam logic [1:0] MULDIV_OP_MULTU = 2'd1;
   localparam logic [1:0] MULDIV_OP_DIV   = 2'd2;
   localparam logic [1:0] MULDIV_OP_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

   function automatic logic op_is_div(input logic [1:0] op);
      return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2_step.sv
// One restoring radix-2 divide step: shift the next dividend bit into the
// remainder and subtract the divisor when it fits.
module div_radix2_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quotient,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quotient
);

   logic [WIDTH:0] w_trial;
   logic           w_fits;

   assign w_trial = {i_rem, i_quotient[WIDTH-1]};
   assign w_fits  = (w_trial >= {1'b0, i_divisor});

   // When the divisor fits, trial - divisor < divisor, so the low WIDTH bits are exact.
   assign o_rem      = w_fits ? (w_trial[WIDTH-1:0] - i_divisor) : w_trial[WIDTH-1:0];
   assign o_quotient = {i_quotient[WIDTH-2:0], w_fits};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit driving a single HI/LO write pulse.
// MUL_SINGLE_CYCLE_EN: multiplies complete at the accept edge (IDLE -> DONE).
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             w_en_hi,
   output logic [WIDTH-1:0] data_hi,
   output logic             w_en_lo,
   output logic [WIDTH-1:0] data_lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_t        r_state, w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic             r_neg_q, r_neg_r;
   logic [WIDTH-1:0] r_opnd, r_hi, r_lo;
   logic             r_busy, r_w_en;
   logic [WIDTH-1:0] r_data_hi, r_data_lo;

   logic               w_accept, w_sa, w_sb, w_div_zero;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_div_rem, w_div_quo, w_fix_hi, w_fix_lo;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_prod_neg;

   assign w_accept = (r_state == MD_IDLE) && start && !cancel;
   assign w_sa     = op_is_signed(op) & src_a[WIDTH-1];
   assign w_sb     = op_is_signed(op) & src_b[WIDTH-1];
   assign w_mag_a  = w_sa ? -src_a : src_a;
   assign w_mag_b  = w_sb ? -src_b : src_b;

   // Multiply: {r_hi, r_lo} starts as {0, multiplier}; r_opnd is the multiplicand.
   assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
   assign w_div_zero = (r_opnd == '0);
   assign w_prod_neg = -{r_hi, r_lo};

   // Divide: r_hi is the remainder, r_lo shifts the dividend out and the quotient in.
   div_radix2_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem      (r_hi),
      .i_quotient (r_lo),
      .i_divisor  (r_opnd),
      .o_rem      (w_div_rem),
      .o_quotient (w_div_quo)
   );

`ifdef MUL_SINGLE_CYCLE_EN
   logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_fast_prod;
   assign w_ext_a     = {{WIDTH{w_sa}}, src_a};
   assign w_ext_b     = {{WIDTH{w_sb}}, src_b};
   assign w_fast_prod = w_ext_a * w_ext_b;
`endif

   // Divide-by-zero leaves the all-ones quotient alone; negating the remainder restores src_a.
   always_comb begin
      w_fix_hi = r_hi;
      w_fix_lo = r_lo;
      if (op_is_div(r_op)) begin
         if (r_neg_q && !w_div_zero) w_fix_lo = -r_lo;
         if (r_neg_r)                w_fix_hi = -r_hi;
      end else if (r_neg_q) begin
         {w_fix_hi, w_fix_lo} = w_prod_neg;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         MD_IDLE: if (start) begin
`ifdef MUL_SINGLE_CYCLE_EN
            w_state_next = op_is_div(op) ? MD_CALC : MD_DONE;
`else
            w_state_next = MD_CALC;
`endif
         end
         MD_CALC: if (r_cnt == CW'(WIDTH - 1)) w_state_next = MD_FIX;
         MD_FIX:  w_state_next = MD_DONE;
         MD_DONE: w_state_next = MD_IDLE;
         default: w_state_next = MD_IDLE;
      endcase
      if (cancel) w_state_next = MD_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= MD_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_opnd    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_w_en    <= 1'b0;
         r_data_hi <= '0;
         r_data_lo <= '0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != MD_IDLE);
         r_w_en  <= (w_state_next == MD_DONE);
         if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_hi    <= '0;
            r_opnd  <= op_is_div(op) ? w_mag_b : w_mag_a;
            r_lo    <= op_is_div(op) ? w_mag_a : w_mag_b;
         end else if (r_state == MD_CALC) begin
            r_cnt <= r_cnt + CW'(1);
            if (op_is_div(r_op)) begin
               r_hi <= w_div_rem;
               r_lo <= w_div_quo;
            end else begin
               r_hi <= w_mul_sum[WIDTH:1];
               r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end
         end
         if (r_state == MD_FIX && w_state_next == MD_DONE) begin
            r_data_hi <= w_fix_hi;
            r_data_lo <= w_fix_lo;
         end
`ifdef MUL_SINGLE_CYCLE_EN
         else if (w_accept && !op_is_div(op)) begin
            r_data_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
            r_data_lo <= w_fast_prod[WIDTH-1:0];
         end
`endif
      end
   end

   assign busy    = r_busy;
   assign w_en_hi = r_w_en;
   assign w_en_lo = r_w_en;
   assign data_hi = r_data_hi;
   assign data_lo = r_data_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit: a timeline model of busy / write pulse / held
// data, compared every cycle, plus literal results for the documented cases.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, cancel = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] src_a = '0, src_b = '0;
   logic         busy, w_en_hi, w_en_lo;
   logic [W-1:0] data_hi, data_lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .cancel(cancel), .busy(busy), .w_en_hi(w_en_hi), .data_hi(data_hi),
      .w_en_lo(w_en_lo), .data_lo(data_lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   // Current transaction: accepted at posedge number t_edge; cycle k=1 follows that edge.
   bit           t_valid = 1'b0, t_pulse = 1'b0;
   int           t_edge = 0, t_lat = 0, t_end = 0;
   logic [W-1:0] t_hi = '0, t_lo = '0, h_hi = '0, h_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (mop)
         MULDIV_OP_MULT:  return sa * sb;
         MULDIV_OP_MULTU: return ua * ub;
         MULDIV_OP_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   function automatic int latency(input logic [1:0] mop);
`ifdef MUL_SINGLE_CYCLE_EN
      if (!op_is_div(mop)) return 1;
`endif
      return W + 2;
   endfunction

   always @(negedge clk) begin
      int k;
      bit eb, ew;
      k  = t_valid ? (cyc - t_edge + 1) : 0;
      eb = t_valid && (k >= 1) && (k <= t_end);
      ew = t_valid && t_pulse && (k == t_lat);
      if (ew) begin
         h_hi = t_hi;
         h_lo = t_lo;
      end
      check("busy", busy, eb);
      check("w_en_hi", w_en_hi, ew);
      check("w_en_lo", w_en_lo, ew);
      check("data_hi", data_hi, h_hi);
      check("data_lo", data_lo, h_lo);
   end

   // Returns 1 ns after posedge number e (no wait if already past it).
   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_k, input bit mid_start, input bit use_lit,
                         input logic [63:0] lit);
      logic [63:0] m;
      int          lat;
      m   = model(o, a, b);
      lat = latency(o);
      if (use_lit) check("model_literal", m, lit);
      @(posedge clk);
      #2;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      t_edge  = cyc;
      t_lat   = lat;
      t_hi    = m[63:32];
      t_lo    = m[31:0];
      t_pulse = (cancel_k == 0) || (cancel_k >= lat);
      t_end   = (cancel_k == 0) ? lat : cancel_k;
      t_valid = 1'b1;
      if (mid_start) begin
         wait_edge(t_edge + 4);
         #1;
         start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      if (cancel_k > 0) begin
         wait_edge(t_edge + cancel_k - 1);
         #1;
         cancel = 1'b1;
         @(posedge clk);
         #1;
         cancel = 1'b0;
      end
      wait_edge(t_edge + t_end + 1);
      if (use_lit) begin
         check("final_hi", data_hi, lit[63:32]);
         check("final_lo", data_lo, lit[31:0]);
      end
   endtask

   task automatic reset_mid();
      logic [31:0] a, b;
      logic [63:0] m;
      a = $urandom;
      b = $urandom | 32'd1;
      m = model(MULDIV_OP_DIVU, a, b);
      @(posedge clk);
      #2;
      start = 1'b1; op = MULDIV_OP_DIVU; src_a = a; src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      t_edge = cyc; t_lat = W + 2; t_end = W + 2; t_pulse = 1'b1;
      t_hi = m[63:32]; t_lo = m[31:0]; t_valid = 1'b1;
      wait_edge(t_edge + 8);
      #2;
      resetn = 1'b0;
      t_valid = 1'b0; h_hi = '0; h_lo = '0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_w_en", {w_en_hi, w_en_lo}, 2'b00);
      check("rst_data_hi", data_hi, '0);
      check("rst_data_lo", data_lo, '0);
      repeat (2) @(posedge clk);
      #3;
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #28;
      resetn = 1'b1;
      run_op(MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 64'hFFFF_FFFE_0000_0001);
      run_op(MULDIV_OP_MULT,  32'hFFFF_FFFD, 32'd5,         0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(MULDIV_OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(MULDIV_OP_DIVU,  32'd100,       32'd7,         0, 1, 1, 64'h0000_0002_0000_000E);
      run_op(MULDIV_OP_DIVU,  32'd100,       32'd0,         0, 0, 1, 64'h0000_0064_FFFF_FFFF);
      run_op(MULDIV_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 64'h0000_0000_8000_0000);
      run_op(MULDIV_OP_DIV,   32'hFFFF_FFFB, 32'd0,         0, 0, 1, 64'hFFFF_FFFB_FFFF_FFFF);
      run_op(MULDIV_OP_DIVU,  $urandom,      $urandom,     10, 1, 0, 64'd0);
      run_op(MULDIV_OP_MULTU, 32'd6,         32'd7,         0, 0, 1, 64'h0000_0000_0000_002A);

      // start together with cancel in IDLE must not launch anything
      @(posedge clk);
      #2;
      start = 1'b1; cancel = 1'b1; op = MULDIV_OP_MULTU; src_a = 32'd3; src_b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0; cancel = 1'b0;
      repeat (3) @(posedge clk);

      reset_mid();
      run_op(MULDIV_OP_MULT, 32'hFFFF_FFF9, 32'd6, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFD6);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         int          lat, ck;
         bit          ms;
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: a = 32'($urandom_range(0, 1000));
            default: ;
         endcase
         lat = latency(o);
         ck  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
         ms  = (lat > 5) && (ck == 0 || ck > 5) && ($urandom_range(0, 1) == 1);
         run_op(o, a, b, ck, ms, 0, 64'd0);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
